// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants for the 1-to-2 demultiplexer
package demux_pkg;

    localparam int DATA_W_DEF = 2;
    localparam int CNT_W_DEF  = 4;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux_lane.sv
// rtl/demux_lane.sv - one output lane: single-entry register, handshake, delivered-word counter
module demux_lane
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              free,
    output logic [CNT_W-1:0]  cnt
);

    logic deliver;

    assign deliver = valid && ready;
    // The slot can take a new word if empty or if its word leaves this cycle.
    assign free    = !valid || ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (deliver) begin
            valid <= 1'b0;
        end
    end

    // Wraps modulo 2^CNT_W by natural overflow.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
        end else if (deliver) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux_mem.sv
// rtl/demux_mem.sv - 1-to-2 demultiplexer with manual or round-robin lane choice
module demux_mem
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              selector,
    input  logic              auto_mode,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    input  logic              ready0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    input  logic              ready1,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic rr_sel;
    logic tgt;
    logic free0;
    logic free1;
    logic accept;

    // Input is only as ready as its chosen lane, so words never overtake each other.
    assign tgt       = auto_mode ? rr_sel : selector;
    assign ready_out = (tgt == LANE1) ? free1 : free0;
    assign accept    = valid_in && ready_out;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_sel <= LANE0;
        end else if (accept && auto_mode) begin
            rr_sel <= ~rr_sel;
        end
    end

    demux_lane #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane0 (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (accept && (tgt == LANE0)),
        .din     (data_in),
        .ready   (ready0),
        .dout    (data_out0),
        .valid   (valid_out0),
        .free    (free0),
        .cnt     (cnt0)
    );

    demux_lane #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane1 (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (accept && (tgt == LANE1)),
        .din     (data_in),
        .ready   (ready1),
        .dout    (data_out1),
        .valid   (valid_out1),
        .free    (free1),
        .cnt     (cnt1)
    );

endmodule

// File: tb/tb_demux_mem.sv
// tb/tb_demux_mem.sv - self-checking bench for demux_mem with a behavioural lane model
module tb_demux_mem;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [1:0] data_in = 2'b00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       selector = 1'b0;
    logic       auto_mode = 1'b0;
    logic [1:0] data_out0;
    logic       valid_out0;
    logic       ready0 = 1'b0;
    logic [1:0] data_out1;
    logic       valid_out1;
    logic       ready1 = 1'b0;
    logic [3:0] cnt0;
    logic [3:0] cnt1;

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 1'b0;

    // Model: what each lane is holding, the last word it was given, and total deliveries.
    bit         m_hold [2];
    logic [1:0] m_last [2];
    int         m_deliv[2];
    bit         m_rr;

    demux_mem #(.DATA_W(2), .CNT_W(4)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .selector   (selector),
        .auto_mode  (auto_mode),
        .data_out0  (data_out0),
        .valid_out0 (valid_out0),
        .ready0     (ready0),
        .data_out1  (data_out1),
        .valid_out1 (valid_out1),
        .ready1     (ready1),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_ready();
        int t;
        bit [1:0] rdy;
        rdy = {ready1, ready0};
        t = auto_mode ? int'(m_rr) : int'(selector);
        return !m_hold[t] || rdy[t];
    endfunction

    initial begin
        for (int l = 0; l < 2; l++) begin
            m_hold[l] = 0; m_last[l] = 2'b00; m_deliv[l] = 0;
        end
        m_rr = 0;
        forever begin
            @(posedge clk or negedge reset_L);
            if (!reset_L) begin
                for (int l = 0; l < 2; l++) begin
                    m_hold[l] = 0; m_last[l] = 2'b00; m_deliv[l] = 0;
                end
                m_rr = 0;
            end else begin
                int  t;
                bit  acc;
                bit [1:0] rdy;
                rdy = {ready1, ready0};
                t   = auto_mode ? int'(m_rr) : int'(selector);
                acc = valid_in && (!m_hold[t] || rdy[t]);
                for (int l = 0; l < 2; l++) begin
                    if (m_hold[l] && rdy[l]) begin
                        m_deliv[l]++;
                        m_hold[l] = 0;
                    end
                end
                if (acc) begin
                    m_last[t] = data_in;
                    m_hold[t] = 1;
                    if (auto_mode) m_rr = !m_rr;
                end
            end
        end
    end

    initial begin
        while (!done) begin
            @(negedge clk);
            #2;
            if (!done) begin
                check("ready_out",  int'(ready_out),  int'(model_ready()));
                check("valid_out0", int'(valid_out0), int'(m_hold[0]));
                check("valid_out1", int'(valid_out1), int'(m_hold[1]));
                check("data_out0",  int'(data_out0),  int'(m_last[0]));
                check("data_out1",  int'(data_out1),  int'(m_last[1]));
                check("cnt0",       int'(cnt0),       m_deliv[0] % 16);
                check("cnt1",       int'(cnt1),       m_deliv[1] % 16);
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] d, input bit s, input bit a,
                         input bit r0, input bit r1);
        @(negedge clk);
        #1;
        valid_in  = v;
        data_in   = d;
        selector  = s;
        auto_mode = a;
        ready0    = r0;
        ready1    = r1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] w;
        reset_L = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_L = 1'b1;

        // Asynchronous reset while lane0 holds a stalled word
        drive(1, 2'b01, 0, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0);
        after_edge();
        check("t1_valid0_before_reset", int'(valid_out0), 1);
        #2 reset_L = 1'b0;
        #1;
        check("t1_valid0_async", int'(valid_out0), 0);
        check("t1_data0_async",  int'(data_out0),  0);
        check("t1_cnt0_async",   int'(cnt0),       0);
        @(negedge clk);
        #1 reset_L = 1'b1;
        #1;
        check("t1_ready_after_release", int'(ready_out), 1);

        // Manual routing
        drive(1, 2'b01, 0, 0, 1, 1);
        after_edge();
        check("t2_data0_w1", int'(data_out0), 1);
        drive(1, 2'b10, 1, 0, 1, 1);
        after_edge();
        check("t2_data1_w2", int'(data_out1), 2);
        drive(1, 2'b11, 0, 0, 1, 1);
        after_edge();
        check("t2_data0_w3", int'(data_out0), 3);
        drive(0, 2'b00, 0, 0, 1, 1);
        after_edge();
        check("t2_cnt0", int'(cnt0), 2);
        check("t2_cnt1", int'(cnt1), 1);

        // Round-robin, then pause auto_mode and resume
        drive(1, 2'b00, 1, 1, 1, 1);
        after_edge();
        check("t3_rr_lane0", int'(valid_out0), 1);
        drive(1, 2'b01, 0, 1, 1, 1);
        after_edge();
        check("t3_rr_lane1", int'(data_out1), 1);
        drive(1, 2'b10, 1, 1, 1, 1);
        after_edge();
        check("t3_rr_lane0b", int'(data_out0), 2);
        drive(1, 2'b00, 0, 0, 1, 1);
        after_edge();
        check("t3_manual_lane0", int'(data_out0), 0);
        drive(1, 2'b11, 0, 1, 1, 1);
        after_edge();
        check("t3_resume_lane1", int'(data_out1), 3);
        check("t3_resume_valid1", int'(valid_out1), 1);

        // Backpressure on lane0
        drive(1, 2'b10, 0, 0, 0, 1);
        after_edge();
        check("t4_held_data0", int'(data_out0), 2);
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'b01, 0, 0, 0, 1);
            #1;
            check("t4_stall_ready", int'(ready_out), 0);
            after_edge();
            check("t4_stall_data0", int'(data_out0), 2);
        end
        check("t4_cnt0_stalled", int'(cnt0), 5);
        drive(1, 2'b01, 1, 0, 0, 1);
        #1;
        check("t4_other_lane_ready", int'(ready_out), 1);
        after_edge();
        check("t4_lane1_took", int'(data_out1), 1);
        drive(0, 2'b00, 0, 0, 1, 1);
        after_edge();
        check("t4_cnt0_released", int'(cnt0), 6);
        check("t4_valid0_drained", int'(valid_out0), 0);

        // Back-to-back words into lane0
        for (int i = 0; i < 8; i++) begin
            w = 2'(i + 1);
            drive(1, w, 0, 0, 1, 1);
            after_edge();
            check("t5_valid0", int'(valid_out0), 1);
            check("t5_data0",  int'(data_out0),  int'(w));
        end
        drive(0, 2'b00, 0, 0, 1, 1);

        // Counter wrap on lane1 from a fresh reset
        @(negedge clk);
        #1 reset_L = 1'b0;
        @(negedge clk);
        #1 reset_L = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w = 2'(i);
            drive(1, w, 1, 0, 1, 1);
            after_edge();
            if (i == 15) check("t6_cnt1_15", int'(cnt1), 15);
            if (i == 16) check("t6_cnt1_wrap", int'(cnt1), 0);
        end
        drive(0, 2'b00, 0, 0, 1, 1);
        after_edge();
        check("t6_cnt1_after_wrap", int'(cnt1), 1);

        repeat (2) @(negedge clk);
        done = 1'b1;
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_mem.md
Name: demux_mem

Overview:
- 1-to-2 demultiplexer for 2-bit data words. It is the distribution end of the 2-input registered mux path.
- Accepts one input word stream with a valid/ready handshake and routes each word to one of two registered output lanes.
- Lane choice comes from an explicit selector or from internal round-robin alternation.
- Each lane has its own valid/ready handshake and a wrapping delivered-word counter.
- Sits downstream of a mux stage, splitting a merged stream back into two consumers.

Parameters:
- DATA_W, 2, width of the data word.
- CNT_W, 4, width of each per-lane delivered-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_L  input  1  reset, asynchronous, active-low.
- data_in  input  DATA_W  input word.
- valid_in  input  1  data_in valid.
- ready_out  output  1  block can accept data_in this cycle.
- selector  input  1  target lane when auto_mode=0 (0 -> lane0, 1 -> lane1).
- auto_mode  input  1  1 = round-robin lane choice, selector ignored.
- data_out0  output  DATA_W  lane0 word.
- valid_out0  output  1  lane0 word valid.
- ready0  input  1  lane0 consumer ready.
- data_out1  output  DATA_W  lane1 word.
- valid_out1  output  1  lane1 word valid.
- ready1  input  1  lane1 consumer ready.
- cnt0  output  CNT_W  words delivered on lane0.
- cnt1  output  CNT_W  words delivered on lane1.

Behaviour:
- Single clock domain (clk). Reset is asynchronous, active-low on reset_L. All state is cleared immediately on reset_L=0, independent of clk.
- Reset values:
  - data_out0 = data_out1 = 0
  - valid_out0 = valid_out1 = 0
  - cnt0 = cnt1 = 0
  - internal rr_sel = 0
- Target lane: tgt = auto_mode ? rr_sel : selector.
- Lane free: freeX = !valid_outX || readyX.
- ready_out = free[tgt]. Combinational; no dependence on valid_in.
- Accept: valid_in && ready_out. On accept, at the next clk edge:
  - data_out[tgt] <= data_in
  - valid_out[tgt] <= 1
- Latency: 1 cycle from accept to valid_outX.
- Lane drain: valid_outX && readyX with no new accept into that lane -> valid_outX <= 0. data_outX holds its last value.
- Simultaneous drain and accept on the same lane: new word loaded, valid_outX stays 1. Full throughput, 1 word/cycle.
- Stall: while valid_outX && !readyX, data_outX and valid_outX hold stable. A word targeting lane X is not accepted (ready_out=0). The other lane keeps its own state.
- No reordering: a stalled tgt blocks the input even if the other lane is free.
- rr_sel:
  - toggles on each accept while auto_mode=1
  - holds while auto_mode=0
  - auto_mode changes take effect combinationally in the same cycle
- Counters:
  - cntX increments on each delivery (valid_outX && readyX)
  - modulo 2^CNT_W: 15 -> 0 at CNT_W=4
  - no saturation
- valid_in=0: no state change except lane drains and counter increments.
- Reset mid-operation: buffered words are discarded, counters cleared, rr_sel=0. Output ports take their reset values while reset_L=0.

Decomposition:
- Shared package demux_pkg:
  - constants DATA_W_DEF=2, CNT_W_DEF=4
  - lane index constants LANE0=0, LANE1=1
- Sub-module demux_lane, instantiated twice. Contents:
  - one-entry output register with valid
  - load/drain logic
  - CNT_W delivered counter
  - ports: clk, reset_L, load, din, ready, dout, valid, free, cnt
- Top level holds tgt selection, rr_sel, and the ready_out/accept logic.

Test Plan:
1. Reset: assert reset_L=0 mid-clock with valid_out0=1 -> all outputs 0 immediately without a clk edge. After release, ready_out=1.
2. Manual routing: auto_mode=0, ready0=ready1=1; send 2'b01 sel=0, 2'b10 sel=1, 2'b11 sel=0 on consecutive cycles.
   - data_out0=01, data_out1=10, data_out0=11, each one cycle after accept.
   - cnt0=2, cnt1=1.
3. Round-robin: auto_mode=1, valid_in held, words 00,01,10,11.
   - Lanes alternate 0,1,0,1 starting at lane0.
   - Clear auto_mode after 3 words -> rr_sel held at 1. Setting auto_mode=1 again -> next word goes to lane1.
4. Backpressure: lane0 holds 2'b10 with ready0=0; offer next word to lane0.
   - ready_out=0, data_out0 stays 10 for 5 cycles.
   - Switch selector to 1 -> accepted to lane1 immediately.
   - Raise ready0 -> lane0 delivers, cnt0 increments.
5. Back-to-back same lane, ready0=1: 8 consecutive words to lane0 -> valid_out0 continuously 1, one word per cycle, no drops.
6. Counter wrap: 17 deliveries on lane1 with CNT_W=4 -> cnt1 reads 15, then 0, then 1.
